// File: rtl/common.sv
// Shared bus types for the core's instruction, data and cache/memory buses.
// Instruction data is 32 bits wide; data and cbus words are 64 bits wide.
package common;

    typedef logic [31:0] addr_t;
    typedef logic [63:0] word_t;
    typedef logic [31:0] instr_t;
    typedef logic [7:0]  strobe_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } ibus_req_t;

    typedef struct packed {
        logic   addr_ok;
        logic   data_ok;
        instr_t data;
    } ibus_resp_t;

    typedef struct packed {
        logic    valid;
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

    typedef struct packed {
        logic    valid;
        logic    is_write;
        msize_t  size;
        addr_t   addr;
        strobe_t strobe;
        word_t   data;
    } cbus_req_t;

    typedef struct packed {
        logic  ready;
        logic  last;
        word_t data;
    } cbus_resp_t;

endpackage

// File: rtl/pipes.sv
// Pipeline-side control types shared by the core's infrastructure blocks.
// Holds the memory-bus arbiter state encoding.
package pipes;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/bus_arbiter.sv
// Merges the core's instruction and data buses onto the single cbus port.
// One latched transfer at a time; the response is routed back to its owner.
module bus_arbiter
    import common::*;
    import pipes::*;
#(
    parameter int ARB_MODE = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output cbus_req_t  creq,
    input  cbus_resp_t cresp
);

    arb_state_t state;
    arb_state_t state_nxt;
    cbus_req_t  saved_req;
    cbus_req_t  saved_nxt;
    logic       last_grant;
    logic       last_grant_nxt;
    logic       abandon;
    logic       abandon_nxt;

    logic grant_i;
    logic grant_d;
    logic busy;
    logic owner_valid;
    logic done;
    logic deliver;

    // last_grant: 1 when data was the most recently granted requester
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (ARB_MODE == 0) begin
            grant_d = dreq.valid;
            grant_i = ireq.valid && !dreq.valid;
        end else begin
            grant_d = dreq.valid && (!ireq.valid || !last_grant);
            grant_i = ireq.valid && (!dreq.valid || last_grant);
        end
    end

    assign busy        = (state != IDLE);
    assign owner_valid = (state == BUSY_D) ? dreq.valid : ireq.valid;
    assign done        = busy && cresp.ready && cresp.last;
    assign deliver     = done && owner_valid && !abandon;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            saved_req  <= '0;
            last_grant <= 1'b0;
            abandon    <= 1'b0;
        end else begin
            state      <= state_nxt;
            saved_req  <= saved_nxt;
            last_grant <= last_grant_nxt;
            abandon    <= abandon_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        saved_nxt      = saved_req;
        last_grant_nxt = last_grant;
        abandon_nxt    = abandon;
        unique case (state)
            IDLE: begin
                abandon_nxt = 1'b0;
                if (grant_d) begin
                    state_nxt          = BUSY_D;
                    last_grant_nxt     = 1'b1;
                    saved_nxt          = '0;
                    saved_nxt.is_write = |dreq.strobe;
                    saved_nxt.size     = dreq.size;
                    saved_nxt.addr     = dreq.addr;
                    saved_nxt.strobe   = dreq.strobe;
                    saved_nxt.data     = dreq.data;
                end else if (grant_i) begin
                    state_nxt      = BUSY_I;
                    last_grant_nxt = 1'b0;
                    saved_nxt      = '0;
                    saved_nxt.size = MSIZE4;
                    saved_nxt.addr = ireq.addr;
                end
            end
            BUSY_I, BUSY_D: begin
                // a flushed owner keeps the cbus transfer alive but loses data_ok
                if (!owner_valid) begin
                    abandon_nxt = 1'b1;
                end
                if (done) begin
                    state_nxt   = IDLE;
                    abandon_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        creq       = saved_req;
        creq.valid = busy;
        iresp      = '0;
        dresp      = '0;
        if (deliver && state == BUSY_I) begin
            iresp.addr_ok = 1'b1;
            iresp.data_ok = 1'b1;
            iresp.data    = cresp.data[31:0];
        end
        if (deliver && state == BUSY_D) begin
            dresp.addr_ok = 1'b1;
            dresp.data_ok = 1'b1;
            dresp.data    = cresp.data;
        end
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-requester memory-bus arbiter between the pipeline core and the single shared cache/memory port. It merges the core's instruction bus (fetch) and data bus (memory stage) onto one `cbus` channel. Each granted request is latched and held on `cbus` until the memory side completes it, and the response is routed back to the owning requester. It sits directly under the SoC top, between `core` (ports `ireq/iresp/dreq/dresp`) and the memory/cache model.

## Interface
Parameters:
- `ARB_MODE`, default 0: 0 = fixed priority, data over instruction; 1 = round-robin between the two requesters.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  reset; one clock, asynchronous, active-low.
- `ireq`  in  `ibus_req_t`  instruction request (`valid`, `addr`).
- `iresp`  out  `ibus_resp_t`  instruction response (`addr_ok`, `data_ok`, `data`).
- `dreq`  in  `dbus_req_t`  data request (`valid`, `addr`, `size`, `strobe`, `data`).
- `dresp`  out  `dbus_resp_t`  data response (`addr_ok`, `data_ok`, `data`).
- `creq`  out  `cbus_req_t`  shared request (`valid`, `is_write`, `size`, `addr`, `strobe`, `data`).
- `cresp`  in  `cbus_resp_t`  shared response (`ready`, `last`, `data`).

## Operation
- **FSM states.** `IDLE`, `BUSY_I`, `BUSY_D`. The state register and the latched request register reset to `IDLE` / all-zero.
- **Grant (IDLE only).** Grant is evaluated on `ireq.valid` and `dreq.valid`.
  - `ARB_MODE=0`: data wins whenever `dreq.valid`.
  - `ARB_MODE=1`: if both are valid, grant the requester not served last. The `last_grant` flop resets to "instruction", so data goes first after reset.
  - At the grant edge, the winner's fields are latched into `saved_req` and the state moves to `BUSY_I` or `BUSY_D`.
- **Latched request construction.**
  - Instruction: `is_write=0`, `size=MSIZE4`, `strobe=0`, `data=0`.
  - Data: `is_write = |dreq.strobe`, with `size`, `strobe`, `data` copied from `dreq`.
- **creq.** `creq` is driven only from `saved_req`, never combinationally from `ireq`/`dreq`. `creq.valid=1` exactly while in a BUSY state.
- **Completion.** In a BUSY state, `cresp.ready && cresp.last` completes the transfer. The state returns to `IDLE` at that edge.
- **Response routing (combinational).**
  - In the completion cycle, the owner's `addr_ok` and `data_ok` are both 1 and its `data` equals `cresp.data`.
  - The non-owner's response is all-zero.
  - Outside completion cycles, both responses are all-zero.
- **Abandon.** If the owner's `valid` drops during BUSY (pipeline flush), the arbiter sets an `abandon` flop. The `cbus` transfer still runs to completion, because `cbus` has no abort. No `data_ok` is issued for it, and `abandon` clears on return to `IDLE`.
- **Request stability.** Requesters hold their fields stable until `data_ok`. The arbiter does not re-sample them during BUSY.
- **Ignored responses.** `cresp.ready` seen in `IDLE` is ignored.

## Timing
- **Reset.** While `reset_n=0`, all outputs are 0, `creq.valid=0` immediately (asynchronous), and the state is `IDLE`. Reset in mid-transfer drops the transfer without any response.
- **Minimum latency.** Request valid in cycle 0 (`IDLE`) → `creq.valid` in cycle 1. If memory completes in cycle 1, `data_ok` is also in cycle 1.
- **Throughput.** Back-to-back grants have one `IDLE` cycle between transfers: at most one transfer per 2 cycles.
- **Simultaneous events.**
  - Completion and a new request in the same cycle: the new grant happens in the following `IDLE` cycle.
  - Both requesters valid in `IDLE`: the grant follows `ARB_MODE`.
  - A request arriving while BUSY waits; there is no preemption.
- **Completion condition.** `cresp.last` without `ready` is not a completion.
- **Starvation.** In `ARB_MODE=0`, instruction fetch can starve under continuous data traffic. This is accepted, because the memory stage stalls fetch anyway.

## Structure
- `ibus_*`, `dbus_*`, `cbus_*` types and `MSIZE*` constants live in `common`.
- `arb_state_t` (the 3-state enum) goes in the `pipes` package.
- Single module with no sub-module. The request-latch mux is inline.

## Test plan
- **Single fetch.** `ireq.valid=1`, `addr=0x8000_0000`; memory returns `ready=last=1` with `data=0x00000513` in the first BUSY cycle → `creq.valid` in cycle 1 with `is_write=0`, `size=MSIZE4`; `iresp.data_ok=1` and `iresp.data=0x00000513` in cycle 1; `dresp` all-zero.
- **Contention, `ARB_MODE=0`.** Both valid in the same cycle; data is a store with `addr=0x8000_1000`, `strobe=0xFF`, `data=0x1234` → data is served first with `creq.is_write=1`; instruction is granted in the `IDLE` cycle after data completes.
- **Contention, `ARB_MODE=1`.** Both requesters held valid for 4 transfers → grant order D, I, D, I.
- **Abandon.** Fetch granted, memory waits 3 cycles, `ireq.valid` drops after 1 cycle → `creq.valid` stays high until `ready&&last`; `iresp.data_ok` is never asserted; the next request is granted normally.
- **Reset mid-transfer.** Assert `reset_n=0` during `BUSY_D` → `creq.valid=0` in the same cycle, no `dresp.data_ok`, state `IDLE` after release.
- **Spurious response.** `cresp.ready=1` while `IDLE` → no `data_ok` on either requester.
